// File: rtl/image_window_ctrl.sv
// 3x3 window producer: a raster pixel stream fills four rotating line buffers,
// and one registered window per cycle is read out of three of them.
module image_window_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [DATA_W-1:0]     i_pixel_data,
  input  logic                  i_pixel_data_valid,
  output logic                  o_pixel_ready,
  output logic [9*DATA_W-1:0]   o_pixel_data,
  output logic                  o_pixel_data_valid,
  output logic                  o_intr
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int OCC_W = $clog2(4*IMG_WIDTH+1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(4*IMG_WIDTH);
  localparam logic [OCC_W-1:0] RD_OCC   = OCC_W'(3*IMG_WIDTH);
  localparam logic [OCC_W-1:0] LINE_OCC = OCC_W'(IMG_WIDTH);

  typedef enum logic {IDLE, RD_BUF} state_t;

  state_t             state;
  state_t             next_state;
  logic [COL_W-1:0]   wr_col;
  logic [1:0]         wr_lb;
  logic [COL_W-1:0]   rd_col;
  logic [1:0]         rd_lb;
  logic [OCC_W-1:0]   tot_pix;
  logic               wr_accept;
  logic               rd_en;
  logic               line_done;

  logic [DATA_W-1:0]  lb_mem [4][IMG_WIDTH];

  assign o_pixel_ready = (tot_pix != FULL_OCC);
  assign wr_accept     = i_pixel_data_valid & o_pixel_ready;

  // Buffer RAM is deliberately not reset; stale contents are never addressed.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      lb_mem[wr_lb][wr_col] <= i_pixel_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_col <= '0;
      wr_lb  <= '0;
    end else if (wr_accept) begin
      if (wr_col == COL_W'(IMG_WIDTH-1)) begin
        wr_col <= '0;
        wr_lb  <= wr_lb + 2'd1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // A write and a line release in the same cycle both land in the count.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      tot_pix <= '0;
    end else begin
      tot_pix <= tot_pix + OCC_W'(wr_accept) - (line_done ? LINE_OCC : '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tot_pix >= RD_OCC) next_state = RD_BUF;
      RD_BUF:  if (line_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = (state == RD_BUF);
    line_done = rd_en && (rd_col == COL_W'(IMG_WIDTH-3));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_col <= '0;
      rd_lb  <= '0;
    end else if (line_done) begin
      rd_col <= '0;
      rd_lb  <= rd_lb + 2'd1;
    end else if (rd_en) begin
      rd_col <= rd_col + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_en;
      o_intr             <= line_done;
    end
  end

  // Tap k = 3*row + col reads line rd_lb+row at column rd_col+col.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    localparam int ROW = gi / 3;
    localparam int COL = gi % 3;
    logic [1:0]        lb_sel;
    logic [COL_W-1:0]  col_sel;
    logic [DATA_W-1:0] tap;

    assign lb_sel  = rd_lb + 2'(ROW);
    assign col_sel = rd_col + COL_W'(COL);

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        tap <= '0;
      end else if (rd_en) begin
        tap <= lb_mem[lb_sel][col_sel];
      end
    end

    assign o_pixel_data[gi*DATA_W +: DATA_W] = tap;
  end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Scoreboard bench for image_window_ctrl: the stimulus side records the image and
// queues every expected window; a negedge monitor checks what the DUT presents.
module tb_image_window_ctrl;
  localparam int  W  = 8;
  localparam int  DW = 8;
  localparam time P  = 10;

  logic           clk = 1'b0;
  logic           rstn;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           ready;
  logic [9*DW-1:0] out_data;
  logic           out_valid;
  logic           intr;

  always #(P/2) clk = ~clk;

  image_window_ctrl #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_pixel_data       (in_data),
    .i_pixel_data_valid (in_valid),
    .o_pixel_ready      (ready),
    .o_pixel_data       (out_data),
    .o_pixel_data_valid (out_valid),
    .o_intr             (intr)
  );

  typedef struct {
    logic [9*DW-1:0] data;
    logic            intr;
    int              col;
    bit              first;
  } win_t;

  win_t          exp_q[$];
  logic [DW-1:0] pix[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  intr_count  = 0;
  int  simul       = 0;
  bit  mon_en      = 1'b0;
  time fill_time   = 0;
  time prev_valid_time = 0;
  time last_acc_time   = 0;

  task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the image is a flat list of accepted pixels; each new full
  // line completes a 3-line group whose W-2 windows are queued in column order.
  task automatic push_pixel(input logic [DW-1:0] p);
    int g;
    win_t e;
    pix.push_back(p);
    if (pix.size() == 3*W) fill_time = $time;
    if (pix.size() % W == 0 && pix.size() / W >= 3) begin
      g = pix.size() / W - 3;
      for (int c = 0; c <= W-3; c++) begin
        e.data = '0;
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++)
            e.data[(3*r+k)*DW +: DW] = pix[(g+r)*W + c + k];
        e.intr  = (c == W-3);
        e.col   = c;
        e.first = (g == 0 && c == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns whether the pixel was accepted at the next edge.
  task automatic send(input logic [DW-1:0] p, input bit v, output bit acc);
    in_valid = v;
    in_data  = p;
    acc = v && ready && rstn;
    @(posedge clk);
    if (acc) begin
      push_pixel(p);
      last_acc_time = $time;
    end
    #1;
    in_valid = 1'b0;
  endtask

  // mode: 0 = row*16+col pattern, 1 = random; gap: 0 none, 1 toggle, 2 random
  task automatic stream(input int n, input int mode, input int gap);
    int sent = 0;
    bit acc;
    bit v = 1'b1;
    logic [DW-1:0] p;
    while (sent < n) begin
      if (mode == 0) p = DW'((pix.size() / W) * 16 + (pix.size() % W));
      else           p = DW'($urandom_range(0, 255));
      if (gap == 2) v = ($urandom_range(0, 3) != 0);
      send(p, v, acc);
      if (acc) sent++;
      if (gap == 1) v = ~v;
    end
  endtask

  task automatic clear_model();
    pix.delete();
    exp_q.delete();
    intr_count = 0;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    repeat (n-1) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      win_t e;
      int occ;
      if (intr) begin
        intr_count++;
        check("intr_with_valid", out_valid, 1'b1);
        if (last_acc_time == $time - P/2) simul++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", out_data, '0);
          if (out_data === '0) begin
            miscompares++;
            $display("FAIL unexpected_window: got valid, expected none at %0t", $time);
          end
        end else begin
          e = exp_q.pop_front();
          check("window", out_data, e.data);
          check("window_intr", intr, e.intr);
          if (e.first) check("first_latency", $time - fill_time, 2*P + P/2);
          if (e.col > 0) check("burst_gap", $time - prev_valid_time, P);
        end
        prev_valid_time = $time;
      end
      occ = pix.size() - W * intr_count;
      check("tot_pix", dut.tot_pix, occ);
      check("ready", ready, occ != 4*W);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end by 2000000");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    int k;
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    // 1: reset held with valid data presented
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_data", out_data, '0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_intr", intr, 1'b0);
      check("rst_ready", ready, 1'b1);
      if (i == 0) mon_en = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rstn     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_totpix", dut.tot_pix, 0);

    // 2: first window, contiguous pattern
    stream(3*W, 0, 0);
    drain();
    check("s2_intr_count", intr_count, 1);

    // 3: gapped pattern
    do_reset(2);
    stream(3*W, 0, 1);
    drain();
    check("s3_intr_count", intr_count, 1);

    // 4: ring wrap over 6 lines
    do_reset(2);
    stream(6*W, 0, 0);
    drain();
    check("s4_intr_count", intr_count, 4);

    // 5: continuous random data; line release coincides with writes
    do_reset(2);
    simul = 0;
    stream(6*W, 1, 0);
    drain();
    check("s5_intr_count", intr_count, 4);
    check("s5_simul_seen", simul > 0, 1'b1);

    // random gaps, long frame with ring rollover several times
    do_reset(2);
    stream(10*W, 1, 2);
    drain();
    check("s5b_intr_count", intr_count, 8);

    // 6: reset on the third window of a burst
    do_reset(2);
    stream(3*W, 0, 0);
    nv = 0;
    k  = 0;
    while (k < 50) begin
      if (out_valid) nv++;
      if (nv == 3) break;
      @(posedge clk);
      #1;
      k++;
    end
    check("s6_third_window", nv, 3);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    check("s6_valid_after_rst", out_valid, 1'b0);
    check("s6_intr_after_rst", intr, 1'b0);
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("s6_no_intr", intr_count, 0);
    stream(3*W, 1, 0);
    drain();
    check("s6_intr_count", intr_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
